// File: rtl/ser_sub_feeder.sv
// ser_sub_feeder: parallel-in/parallel-out wrapper around a bit-serial subtractor (optional `zero` output under SER_SUB_FEEDER_ZERO_FLAG_EN).
// Latency: done is high in the cycle after the WIDTH+2'th posedge following start acceptance; WIDTH+3 cycles per operation.
// Backpressure: start is only sampled in IDLE; while busy=1 further requests are ignored, so callers may hold start high.
module ser_sub_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             s_out,
    output logic             ser_a,
    output logic             ser_b,
    output logic             shift_ctrl,
    output logic             sub_clear_b,
    output logic             busy,
    output logic             done,
`ifdef SER_SUB_FEEDER_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] diff
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  r;
    logic [WIDTH-1:0]  r_next;
    logic [CW-1:0]     count;
    logic              in_clr;

    // Returned bits arrive LSB first, so each new bit enters at the top.
    assign r_next = {s_out, r[WIDTH-1:1]};

    // Subtractor clear: only the CLR state or the block reset pull it low.
    assign sub_clear_b = ~(clear | in_clr);

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs; outputs depend on registered state only.
    always_comb begin
        next_state = state;
        shift_ctrl = 1'b0;
        ser_a      = 1'b0;
        ser_b      = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        in_clr     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = CLR;
            end
            CLR: begin
                in_clr     = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_ctrl = 1'b1;
                ser_a      = a_sr[0];
                ser_b      = b_sr[0];
                if (count == LAST) next_state = DRAIN;
            end
            DRAIN: begin
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand shifters, bit counter, result collector and the held result.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r     <= '0;
            count <= '0;
            diff  <= '0;
`ifdef SER_SUB_FEEDER_ZERO_FLAG_EN
            zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    count <= count + 1'b1;
                    // The first SHIFT cycle has no returned bit yet (subtractor is one cycle behind).
                    if (count != '0) r <= r_next;
                end
                DRAIN: begin
                    r    <= r_next;
                    diff <= r_next;
`ifdef SER_SUB_FEEDER_ZERO_FLAG_EN
                    zero <= (r_next == '0);
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
